// File: rtl/rom_region_loader.sv
// ROM download router: parses the size header at the front of the ioctl stream,
// then steers payload bytes into per-region SDRAM (linear/reorder/byteswap) or BRAM targets.
module rom_region_loader #(
  parameter int NUM_REGIONS = 5,
  parameter int CS_W        = 5,
  parameter logic [NUM_REGIONS*25-1:0]   REGION_BASE = '0,
  parameter logic [NUM_REGIONS*2-1:0]    REGION_MODE = '0,
  parameter logic [NUM_REGIONS*CS_W-1:0] REGION_CS   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ioctl_download,
  input  logic            ioctl_wr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  output logic [24:0]     sdr_addr,
  output logic [15:0]     sdr_data,
  output logic [1:0]      sdr_be,
  output logic            sdr_req,
  input  logic            sdr_ack,
  output logic [24:0]     bram_addr,
  output logic [7:0]      bram_data,
  output logic            bram_wr,
  output logic [CS_W-1:0] bram_cs,
  output logic [7:0]      board_cfg,
  output logic            load_done,
  output logic            load_error
);

  localparam int HDR_LEN = 4 + 4 * NUM_REGIONS;
  localparam int CNT_W   = $clog2(HDR_LEN);
  localparam int IDX_W   = $clog2(NUM_REGIONS + 1);
  localparam logic [1:0] M_REORDER = 2'd1;
  localparam logic [1:0] M_BSWAP   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_SDR_WAIT, S_DONE} state_t;

  state_t                        r_state;
  logic                          r_dl_prev;
  logic [CNT_W-1:0]              r_cnt;
  logic [NUM_REGIONS-1:0][24:0]  r_size;
  logic [IDX_W-1:0]              r_reg;
  logic [24:0]                   r_S, r_Q, r_Q2, r_Q3, r_off;
  logic                          r_final;

  logic [NUM_REGIONS-1:0][24:0]  w_sz;
  logic [31:0]                   w_word;
  logic [IDX_W-1:0]              w_nxt_idx;
  logic                          w_nxt_found;
  logic [24:0]                   w_base, w_ent_S, w_ent_Q, w_ent_Q2, w_ent_Q3;
  logic [1:0]                    w_mode, w_nxt_mode, w_r;
  logic [CS_W-1:0]               w_cs;
  logic [24:0]                   w_sub, w_p, w_d, w_sdr_a, w_off_inc;
  logic                          w_hdr_wr, w_hdr_last, w_data_wr, w_last, w_enter;

  // Size table with the current header byte merged in, so the last header byte
  // can pick the first region in the same cycle it arrives.
  always_comb begin
    w_sz     = r_size;
    w_word   = '0;
    w_hdr_wr = (r_state == S_HDR) && ioctl_download && ioctl_wr;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (w_hdr_wr && r_cnt == CNT_W'(4 + 4 * i + k)) begin
          w_word             = {7'b0, r_size[i]};
          w_word[8*k +: 8]   = ioctl_dout;
          w_sz[i]            = 25'(w_word);
        end
      end
    end
  end

  // First non-zero region after the current one (or from 0 while in the header).
  always_comb begin
    w_nxt_found = 1'b0;
    w_nxt_idx   = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((r_state == S_HDR || IDX_W'(i) > r_reg) && w_sz[i] != '0) begin
        w_nxt_found = 1'b1;
        w_nxt_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_base     = '0;
    w_mode     = '0;
    w_cs       = '0;
    w_nxt_mode = '0;
    w_ent_S    = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_reg == IDX_W'(i)) begin
        w_base = REGION_BASE[25*i +: 25];
        w_mode = REGION_MODE[2*i +: 2];
        w_cs   = REGION_CS[CS_W*i +: CS_W];
      end
      if (w_nxt_idx == IDX_W'(i)) begin
        w_nxt_mode = REGION_MODE[2*i +: 2];
        w_ent_S    = w_sz[i];
      end
    end
  end

  assign w_ent_Q  = {2'b00, w_ent_S[24:2]};
  assign w_ent_Q2 = {1'b0, w_ent_S[24:2], 1'b0};
  assign w_ent_Q3 = w_ent_Q2 + w_ent_Q;

  // Plane interleave: quarter index r lands in bits [2:1], within-quarter offset around it.
  always_comb begin
    w_r = 2'(r_off >= r_Q) + 2'(r_off >= r_Q2) + 2'(r_off >= r_Q3);
    case (w_r)
      2'd0:    w_sub = '0;
      2'd1:    w_sub = r_Q;
      2'd2:    w_sub = r_Q2;
      default: w_sub = r_Q3;
    endcase
    w_p = r_off - w_sub;
    case (w_mode)
      M_REORDER: w_d = 25'({w_p[24:1], w_r, w_p[0]});
      M_BSWAP:   w_d = r_off ^ 25'd1;
      default:   w_d = r_off;
    endcase
  end

  assign w_sdr_a    = w_base + w_d;
  assign w_off_inc  = r_off + 25'd1;
  assign w_last     = (w_off_inc == r_S);
  assign w_hdr_last = w_hdr_wr && (r_cnt == CNT_W'(HDR_LEN - 1));
  assign w_data_wr  = (r_state == S_DATA) && ioctl_download && ioctl_wr;
  assign w_enter    = w_nxt_found && (w_hdr_last || (w_data_wr && w_last));

  always_ff @(posedge clk) begin
    r_dl_prev <= ioctl_download;
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_size     <= '0;
      r_reg      <= '0;
      r_S        <= '0;
      r_Q        <= '0;
      r_Q2       <= '0;
      r_Q3       <= '0;
      r_off      <= '0;
      r_final    <= 1'b0;
      ioctl_wait <= 1'b0;
      sdr_addr   <= '0;
      sdr_data   <= '0;
      sdr_be     <= '0;
      sdr_req    <= 1'b0;
      bram_addr  <= '0;
      bram_data  <= '0;
      bram_wr    <= 1'b0;
      bram_cs    <= '0;
      board_cfg  <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      bram_wr <= 1'b0;
      bram_cs <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (ioctl_download && !r_dl_prev) begin
            r_state    <= S_HDR;
            r_cnt      <= '0;
            r_size     <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
          end
        end
        S_HDR: begin
          if (!ioctl_download) begin
            r_state    <= S_IDLE;
            load_done  <= 1'b1;
            load_error <= 1'b1;
          end else if (ioctl_wr) begin
            if (r_cnt == '0) board_cfg <= ioctl_dout;
            r_size <= w_sz;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_hdr_last) r_state <= w_nxt_found ? S_DATA : S_DONE;
          end
        end
        S_DATA: begin
          if (!ioctl_download) begin
            r_state    <= S_IDLE;
            load_done  <= 1'b1;
            load_error <= 1'b1;
          end else if (ioctl_wr) begin
            if (w_cs != '0) begin
              bram_wr   <= 1'b1;
              bram_cs   <= w_cs;
              bram_addr <= w_d;
              bram_data <= ioctl_dout;
              if (w_last && !w_nxt_found) r_state <= S_DONE;
            end else begin
              sdr_addr   <= w_sdr_a;
              sdr_data   <= {ioctl_dout, ioctl_dout};
              sdr_be     <= w_sdr_a[0] ? 2'b10 : 2'b01;
              sdr_req    <= 1'b1;
              ioctl_wait <= 1'b1;
              r_final    <= w_last && !w_nxt_found;
              r_state    <= S_SDR_WAIT;
            end
            if (!w_last) r_off <= w_off_inc;
          end
        end
        S_SDR_WAIT: begin
          if (ioctl_wr) load_error <= 1'b1;
          if (sdr_ack) begin
            sdr_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            if (r_final) begin
              r_state <= S_DONE;
            end else if (!ioctl_download) begin
              r_state    <= S_IDLE;
              load_done  <= 1'b1;
              load_error <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DONE: begin
          if (ioctl_wr) load_error <= 1'b1;
          if (!ioctl_download) begin
            load_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_enter) begin
        r_reg <= w_nxt_idx;
        r_S   <= w_ent_S;
        r_Q   <= w_ent_Q;
        r_Q2  <= w_ent_Q2;
        r_Q3  <= w_ent_Q3;
        r_off <= '0;
        if (w_nxt_mode == M_REORDER && w_ent_S[1:0] != 2'b00) load_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_region_loader.sv
// Randomized bench for rom_region_loader: a write-list model built from region sizes
// is compared against every SDRAM request and BRAM strobe the DUT produces.
module tb_rom_region_loader;
  localparam int N   = 4;
  localparam int CSW = 5;
  localparam logic [N*25-1:0]  BASE = {25'h020000, 25'h000000, 25'h400000, 25'h100000};
  localparam logic [N*2-1:0]   MODE = {2'd2, 2'd0, 2'd1, 2'd0};
  localparam logic [N*CSW-1:0] CS   = {5'd0, 5'b00100, 5'd0, 5'd0};

  int base_a[N] = '{32'h100000, 32'h400000, 0, 32'h020000};
  int mode_a[N] = '{0, 1, 0, 2};
  int cs_a[N]   = '{0, 0, 4, 0};

  typedef struct {
    bit          bram;
    logic [24:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [4:0]  cs;
  } wr_t;

  logic clk, reset, ioctl_download, ioctl_wr, ioctl_wait, sdr_req, sdr_ack, bram_wr;
  logic load_done, load_error;
  logic [7:0]  ioctl_dout, bram_data, board_cfg;
  logic [24:0] sdr_addr, bram_addr;
  logic [15:0] sdr_data;
  logic [1:0]  sdr_be;
  logic [4:0]  bram_cs;

  int  n_tests = 0, n_fail = 0;
  int  ack_fixed = -1;
  bit  wait_seen;
  wr_t exp_q[$];
  wr_t log_q[$];
  int  dly_q[$];

  rom_region_loader #(
    .NUM_REGIONS(N), .CS_W(CSW), .REGION_BASE(BASE), .REGION_MODE(MODE), .REGION_CS(CS)
  ) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .sdr_addr(sdr_addr), .sdr_data(sdr_data),
    .sdr_be(sdr_be), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .bram_addr(bram_addr),
    .bram_data(bram_data), .bram_wr(bram_wr), .bram_cs(bram_cs), .board_cfg(board_cfg),
    .load_done(load_done), .load_error(load_error)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected write for payload byte b at offset o of region r (size s).
  function automatic wr_t model(input int r, input int o, input int s, input logic [7:0] b);
    wr_t w;
    int q, k, p, d;
    q = s / 4;
    d = o;
    if (mode_a[r] == 1) begin
      if (q == 0) k = 3;
      else begin
        k = o / q;
        if (k > 3) k = 3;
      end
      p = o - k * q;
      d = (p / 2) * 8 + k * 2 + (p % 2);
    end else if (mode_a[r] == 2) begin
      d = o ^ 1;
    end
    if (cs_a[r] != 0) begin
      w.bram = 1; w.addr = 25'(d); w.data = {8'h00, b}; w.be = 2'b00; w.cs = 5'(cs_a[r]);
    end else begin
      w.bram = 0; w.addr = 25'(base_a[r] + d); w.data = {b, b};
      w.be = w.addr[0] ? 2'b10 : 2'b01; w.cs = 5'd0;
    end
    return w;
  endfunction

  // SDRAM responder: acks each request after a random or fixed delay.
  initial begin
    int d;
    sdr_ack = 0;
    forever begin
      @(negedge clk);
      if (sdr_req && !reset) begin
        d = (ack_fixed >= 0) ? ack_fixed : $urandom_range(0, 3);
        dly_q.push_back(d);
        repeat (d) @(negedge clk);
        sdr_ack = 1;
        @(negedge clk);
        sdr_ack = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  logic        m_prev_req = 0;
  logic [24:0] m_addr;
  logic [15:0] m_data;
  logic [1:0]  m_be;
  int          m_len = 0;
  always @(negedge clk) begin
    wr_t g, e;
    int  d;
    if (reset) begin
      m_prev_req = 0;
      m_len      = 0;
    end else begin
      chk("wait_eq_req", {31'b0, ioctl_wait}, {31'b0, sdr_req});
      if (ioctl_wait) wait_seen = 1;
      if (bram_wr || (sdr_req && !m_prev_req)) begin
        if (bram_wr) begin
          g.bram = 1; g.addr = bram_addr; g.data = {8'h00, bram_data}; g.be = 0; g.cs = bram_cs;
        end else begin
          g.bram = 0; g.addr = sdr_addr; g.data = sdr_data; g.be = sdr_be; g.cs = 0;
        end
        log_q.push_back(g);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got addr %0h bram %0d, expected none", g.addr, g.bram);
        end else begin
          e = exp_q.pop_front();
          chk("wr_kind", {31'b0, g.bram}, {31'b0, e.bram});
          chk("wr_addr", {7'b0, g.addr}, {7'b0, e.addr});
          chk("wr_data", {16'b0, g.data}, {16'b0, e.data});
          if (e.bram) chk("bram_cs", {27'b0, g.cs}, {27'b0, e.cs});
          else        chk("sdr_be", {30'b0, g.be}, {30'b0, e.be});
        end
      end
      if (sdr_req && m_prev_req) begin
        chk("req_stable", {sdr_addr, sdr_be, 5'b0}, {m_addr, m_be, 5'b0});
        chk("req_data_stable", {16'b0, sdr_data}, {16'b0, m_data});
      end
      if (sdr_req) m_len++;
      if (!sdr_req && m_prev_req) begin
        d = (dly_q.size() != 0) ? dly_q.pop_front() : -1;
        chk("req_len", m_len, d + 1);
        m_len = 0;
      end
      m_prev_req = sdr_req;
      m_addr = sdr_addr; m_data = sdr_data; m_be = sdr_be;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    ioctl_wr = 0;
    repeat (gap) @(negedge clk);
    t = 0;
    while (ioctl_wait && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL wait_timeout: got ioctl_wait 1 expected 0");
    end
    ioctl_wr = 1;
    ioctl_dout = b;
  endtask

  task automatic end_wr();
    int t;
    @(negedge clk);
    ioctl_wr = 0;
    t = 0;
    while (ioctl_wait && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL end_timeout: got ioctl_wait 1 expected 0");
    end
  endtask

  task automatic run_load(input int sz[N], input logic [7:0] cfg, input int trunc, input bit extra,
                          input bit viol, input bit b2b, input bit fixed);
    int sent, gap;
    bit exp_err, stop;
    logic [31:0] v;
    logic [7:0] b;
    log_q.delete();
    exp_err = 0; sent = 0; stop = 0;
    @(negedge clk); ioctl_download = 1;
    @(negedge clk);
    chk("start_done", {31'b0, load_done}, 0);
    chk("start_err", {31'b0, load_error}, 0);
    gap = b2b ? 0 : $urandom_range(0, 2);
    send_byte(cfg, gap);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), b2b ? 0 : $urandom_range(0, 2));
    for (int i = 0; i < N; i++) begin
      v = {7'($urandom), 25'(sz[i])};
      for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], b2b ? 0 : $urandom_range(0, 2));
      if (mode_a[i] == 1 && sz[i] != 0 && sz[i] % 4 != 0) exp_err = 1;
    end
    for (int i = 0; i < N && !stop; i++) begin
      for (int o = 0; o < sz[i] && !stop; o++) begin
        if (trunc >= 0 && sent == trunc) stop = 1;
        else begin
          b = fixed ? 8'(8'hA0 + sent) : 8'($urandom);
          exp_q.push_back(model(i, o, sz[i], b));
          send_byte(b, b2b ? 0 : $urandom_range(0, 3));
          if (viol && sent == 0) begin
            @(negedge clk);
            ioctl_wr = 0;
            chk("wait_before_viol", {31'b0, ioctl_wait}, 1);
            ioctl_wr = 1; ioctl_dout = 8'hEE;
            exp_err = 1;
          end
          sent++;
        end
      end
    end
    if (stop) exp_err = 1;
    end_wr();
    chk("board_cfg", {24'b0, board_cfg}, {24'b0, cfg});
    chk("done_before_fall", {31'b0, load_done}, 0);
    if (extra) begin
      send_byte(8'h5A, 0);
      end_wr();
      exp_err = 1;
    end
    @(negedge clk); ioctl_download = 0;
    @(negedge clk);
    chk("load_done", {31'b0, load_done}, 1);
    chk("load_error", {31'b0, load_error}, {31'b0, exp_err});
    chk("exp_drained", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ro_off[6] = '{0, 1, 4, 5, 8, 12};
    logic [24:0] ro_adr[6] = '{25'h400000, 25'h400001, 25'h400002, 25'h400003, 25'h400004, 25'h400006};
    int rs[N];
    wr_t w;
    reset = 1; ioctl_download = 0; ioctl_wr = 0; ioctl_dout = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {12'b0, ioctl_wait, sdr_req, sdr_be, bram_wr, bram_cs, load_done, load_error, board_cfg}, 0);
    chk("rst_sdr_addr", {7'b0, sdr_addr}, 0);
    chk("rst_bram_addr", {7'b0, bram_addr}, 0);
    reset = 0;

    // Pin the model with hand-derived addresses.
    for (int i = 0; i < 6; i++) begin
      w = model(1, ro_off[i], 16, 8'h00);
      chk("model_reorder", {7'b0, w.addr}, {7'b0, ro_adr[i]});
    end
    w = model(3, 6, 8, 8'h11);
    chk("model_bswap", {7'b0, w.addr}, 32'h020007);

    // Linear SDRAM, fixed payload A0..A3.
    run_load('{4, 0, 0, 0}, 8'h12, -1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("lin_addr", {7'b0, log_q[i].addr}, 32'h100000 + i);
      chk("lin_be", {30'b0, log_q[i].be}, (i % 2 == 1) ? 2 : 1);
      chk("lin_data", {16'b0, log_q[i].data}, {16'b0, 8'(8'hA0 + i), 8'(8'hA0 + i)});
    end

    // Plane reorder, Q=4.
    run_load('{0, 16, 0, 0}, 8'h00, -1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) chk("ro_addr", {7'b0, log_q[ro_off[i]].addr}, {7'b0, ro_adr[i]});

    // BRAM, back-to-back bytes, no wait.
    wait_seen = 0;
    run_load('{0, 0, 3, 0}, 8'h05, -1, 0, 0, 1, 0);
    chk("bram_cnt", log_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("bram_addr", {7'b0, log_q[i].addr}, i);
    chk("bram_no_wait", {31'b0, wait_seen}, 0);

    // Backpressure: 10-cycle ack hold, plus a write during wait.
    ack_fixed = 10;
    run_load('{2, 0, 0, 0}, 8'h21, -1, 0, 1, 0, 0);
    chk("bp_writes", log_q.size(), 2);
    ack_fixed = -1;

    // Truncation after 2 of 4 bytes.
    run_load('{4, 0, 0, 0}, 8'h83, 2, 0, 0, 0, 0);
    chk("trunc_writes", log_q.size(), 2);

    // Extra byte after DONE; then misaligned reorder size; then empty table.
    run_load('{0, 0, 2, 1}, 8'h40, -1, 1, 0, 0, 0);
    run_load('{0, 6, 0, 0}, 8'h41, -1, 0, 0, 0, 0);
    run_load('{0, 0, 0, 0}, 8'h42, -1, 0, 0, 0, 0);

    // Reset during an outstanding request; the late ack must not write.
    ack_fixed = 8;
    @(negedge clk); ioctl_download = 1;
    @(negedge clk);
    send_byte(8'h77, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) send_byte((i == 0 && k == 0) ? 8'd6 : 8'd0, 0);
    exp_q.push_back(model(0, 0, 6, 8'h3C));
    send_byte(8'h3C, 0);
    @(negedge clk); ioctl_wr = 0;
    chk("req_before_rst", {31'b0, sdr_req}, 1);
    @(negedge clk); reset = 1; ioctl_download = 0;
    @(negedge clk);
    chk("rst_mid_ctrl", {12'b0, ioctl_wait, sdr_req, sdr_be, bram_wr, bram_cs, load_done, load_error, board_cfg}, 0);
    @(negedge clk); reset = 0;
    repeat (12) @(negedge clk);
    chk("late_ack_ignored", {31'b0, sdr_req}, 0);
    chk("rst_exp_drained", exp_q.size(), 0);
    dly_q.delete();
    ack_fixed = -1;

    // Randomized downloads.
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < N; i++) rs[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      run_load(rs, 8'($urandom), -1, 0, 0, $urandom_range(0, 1), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_region_loader.md
# rom_region_loader

Parametrised ROM download router for the M90 family. It parses a size header at the front of the MiSTer ioctl download stream, then steers each following payload byte into one of `NUM_REGIONS` load regions. A region lands either in SDRAM, with optional 64-bit plane interleave or 16-bit byteswap, or in a BRAM selected by chip select. It sits between `hps_io` and the SDRAM/BRAM write arbiters and replaces the fixed five-region table.

## Interface
- `NUM_REGIONS`, 5: number of regions; payload order = index order 0..N-1.
- `CS_W`, 5: BRAM chip-select width.
- `REGION_BASE`, packed N×25 bits, 0: SDRAM byte base address per region; region i is at bits [25i+24:25i].
- `REGION_MODE`, packed N×2 bits, 0: 0 = linear, 1 = reorder_64, 2 = byteswap_16, 3 = reserved (treated as linear).
- `REGION_CS`, packed N×CS_W bits, 0: non-zero routes the region to BRAM with this one-hot cs; zero routes it to SDRAM.
- `clk` in 1: system clock; the block has one clock.
- `reset` in 1: synchronous, active-high reset.
- `ioctl_download` in 1: download active.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_dout` in 8: download byte.
- `ioctl_wait` out 1: backpressure to hps_io.
- `sdr_addr` out 25: SDRAM byte address (bit 0 selects the lane).
- `sdr_data` out 16: write data; the byte is replicated on both lanes.
- `sdr_be` out 2: byte enables.
- `sdr_req` out 1: level request.
- `sdr_ack` in 1: one-cycle acknowledge.
- `bram_addr` out 25: region-relative byte offset.
- `bram_data` out 8: BRAM write byte.
- `bram_wr` out 1: one-cycle write strobe.
- `bram_cs` out CS_W: chip select, valid with `bram_wr`.
- `board_cfg` out 8: header byte 0 (secure, unused, m99, rom_2mbit, bank_mask[3:0]).
- `load_done` out 1: sticky; cleared at the next download start.
- `load_error` out 1: sticky; cleared at the next download start.

## Operation
- Header length H = 4 + 4·N bytes. Byte 0 is `board_cfg`. Bytes 1-3 are reserved and ignored. Then come N sizes, 32-bit little-endian, in bytes; only bits [24:0] are kept.
- States:
  - IDLE: the rising edge of `ioctl_download` goes to HDR and clears the byte counter, `load_done` and `load_error`.
  - HDR: each `ioctl_wr` stores its byte. After byte H-1 the block selects the first region with non-zero size and enters DATA. If no region is non-zero it enters DONE.
  - DATA: each byte is routed at region offset o, then o increments. When o reaches size S the block advances to the next non-zero region; after the last one it enters DONE.
  - SDR_WAIT: holds until `sdr_ack`, then returns to DATA, or to DONE if that was the final byte.
  - DONE: holds until `ioctl_download` falls, then sets `load_done` and returns to IDLE.
- On region entry the block precomputes Q = S>>2, 2Q and 3Q.
- Address mapping for a byte at offset o:
  - Linear: d = o.
  - byteswap_16: d = o ^ 1.
  - reorder_64: r = number of thresholds Q, 2Q, 3Q that o is ≥ (r in 0..3). p = o − r·Q. d = {p[24:1], r[1:0], p[0]}.
- SDRAM route: `sdr_addr` = base + d (25-bit wrap). `sdr_be` = 2'b01 when bit 0 is 0, 2'b10 when bit 0 is 1.
- BRAM route: `bram_addr` = d. The base address is ignored.
- Errors (each sets `load_error`):
  - `ioctl_wr` in DONE: byte is discarded.
  - reorder_64 region with S[1:0] ≠ 0: region is still loaded, using Q = S>>2; the error flag is set at region entry.
  - `ioctl_download` falls in HDR or DATA: the block goes straight to IDLE with `load_done`=1. If SDR_WAIT is active at that moment, it completes the pending request first.

## Timing
- Reset values: every output is 0, `board_cfg`=0, state = IDLE. A reset asserted mid-request drops `sdr_req` on the next edge; a late `sdr_ack` is ignored.
- BRAM path: `ioctl_wr` at cycle n gives `bram_wr`, `bram_addr`, `bram_data` and `bram_cs` registered at n+1, for exactly one cycle. No wait is raised.
- SDRAM path:
  - `ioctl_wr` at n raises `sdr_req` and `ioctl_wait` at n+1.
  - Address, data and byte enables stay stable while `sdr_req` is high.
  - `sdr_ack` at cycle m drops `sdr_req` at m+1 and `ioctl_wait` at m+1.
  - `sdr_ack` in the same cycle as the request rise is legal and gives a single-cycle request.
- `ioctl_wr` that arrives while `ioctl_wait` is high is a protocol violation: the byte is dropped and `load_error` is set.
- `board_cfg` updates on the cycle after header byte 0.
- The region advance happens in the same cycle as the last byte's route, so the next byte can follow on the very next cycle.
- `load_done` rises one cycle after the `ioctl_download` falling edge.

## Test plan
- Linear: N=2, sizes 4 and 0, region 0 linear at base 0x100000. Send 0xA0..0xA3 → SDRAM writes at 0x100000..0x100003 with `sdr_be` 01,10,01,10. Final state DONE; `load_done`=1 after the download falls.
- reorder_64: size 16, base 0x400000 (Q=4). Offsets 0,1,4,5,8,12 → 0x400000, 0x400001, 0x400002, 0x400003, 0x400004, 0x400006.
- BRAM: size 3, cs 5'b00100. Three bytes on back-to-back cycles → three `bram_wr` pulses with addr 0,1,2 and `ioctl_wait` never asserted.
- Backpressure: hold `sdr_ack` low for 10 cycles → `ioctl_wait` stays high for those cycles. Ack at cycle m → `sdr_req` and `ioctl_wait` both low at m+1.
- Truncation: drop `ioctl_download` after 2 of 4 payload bytes → `load_done`=1 and `load_error`=1. An extra byte after DONE also sets `load_error`. Header byte0=0x83 → `board_cfg`=0x83.
- Reset asserted with `sdr_req` high → all outputs 0 on the next edge; a subsequent `sdr_ack` causes no write.
